if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction fetch stage for the RV32I core: owns the fetch PC and issues word reads to
//   instruction memory over a valid/ready request + in-order response interface.
//   Buffers returned words with their PCs in a small FIFO and presents them to decode
//   over a valid/ready handshake.
//   Accepts branch/jump redirects from execute; stale in-flight responses are discarded.
// PARAMETERS
//   XLEN      32   data/address width
//   RESET_PC  0    first fetch address after reset
//   DEPTH     2    FIFO entries; also the cap on (outstanding requests + buffered words)
// PORTS
//   clk             in   1     clock, rising edge
//   rst             in   1     asynchronous reset, active-high
//   imem_req_valid  out  1     fetch request valid
//   imem_req_ready  in   1     memory accepts request this cycle
//   imem_addr       out  XLEN  word address of request (bits[1:0] always 0)
//   imem_rsp_valid  in   1     response word valid; responses return in request order
//   imem_rsp_data   in   XLEN  response instruction word
//   redirect_valid  in   1     execute redirect (taken branch/jump)
//   redirect_pc     in   XLEN  redirect target; bits[1:0] are ignored (forced 0)
//   halt            in   1     level; while high no new requests are issued (core exit)
//   inst_valid      out  1     instruction available to decode
//   inst_ready      in   1     decode consumes instruction
//   inst            out  XLEN  instruction word (0x00000013 NOP when FIFO is empty)
//   inst_pc         out  XLEN  PC of inst (0 when FIFO is empty)
// BEHAVIOUR
// - Reset values: fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, kill_cnt=0, FIFO empty.
//   Outputs under reset: imem_req_valid=0, imem_addr=RESET_PC, inst_valid=0, inst=NOP, inst_pc=0.
// - imem_addr = fetch_pc.
// - Request issue rule:
//   imem_req_valid = !halt && !redirect_valid && (outstanding + fifo_count < DEPTH).
//   The issue condition is purely combinational from registered state and is independent
//   of imem_req_ready.
// - Issue (valid && ready): fetch_pc += 4 (wraps mod 2^XLEN); outstanding += 1.
// - Response (imem_rsp_valid): outstanding -= 1.
//   * If kill_cnt != 0: word dropped, kill_cnt -= 1.
//   * Else: {rsp_pc, data} pushed to the FIFO; rsp_pc += 4.
//   A response in the same cycle as an issue leaves outstanding unchanged.
// - Memory latency is >= 1 cycle, so a response never corresponds to a request issued
//   in the same cycle.
// - Output handshake: inst_valid = FIFO non-empty; inst/inst_pc come from the FIFO head.
//   The head is popped on inst_valid && inst_ready.
//   Zero-cycle bypass from response to inst is not allowed: a word is visible the cycle
//   after its response.
// - Overflow is impossible by construction: space is reserved at issue.
//   Push and pop in the same cycle at full is legal; the count is unchanged.
// - Redirect (highest priority, single cycle):
//   * FIFO flushed, including any word pushed or popped that cycle.
//   * fetch_pc <= {redirect_pc[XLEN-1:2],2'b0}; rsp_pc <= the same value.
//   * kill_cnt <= outstanding - (imem_rsp_valid ? 1 : 0) (the words still in flight).
//   * No request is issued in the redirect cycle.
//   * A second redirect while kill_cnt != 0 recomputes kill_cnt by the same rule.
//   * A redirect while halt is high still updates the PCs and flushes the FIFO.
// - halt only blocks new requests: outstanding responses still complete and are buffered,
//   and the FIFO still drains to decode.
// - Reset mid-operation: all state returns to reset values immediately (async).
//   Responses arriving while rst is high are ignored.
//   After rst falls, the first request is to RESET_PC.
//   Memory must not return responses for pre-reset requests after reset.
// TESTING
// - Reset release, ready=1, 1-cycle memory:
//   imem_addr 0x0,0x4,0x8...; inst_pc 0x0,0x4,0x8 on consecutive cycles after fill;
//   inst matches the memory image.
// - Backpressure: inst_ready=0 for 6 cycles ->
//   at most DEPTH=2 issues total; after release, 0x0 and 0x4 delivered in order, no loss.
// - imem_req_ready toggling 1,0,0,1:
//   imem_addr holds at 0x4 while not ready; no duplicated or skipped PCs at decode.
// - Redirect to 0x102 with 2 requests in flight (3-cycle memory) ->
//   both responses dropped; next inst_pc=0x100; next imem_addr after the redirect cycle is 0x100.
// - halt=1 after 3 issues ->
//   no further requests; the 3 words still reach decode; imem_req_valid stays 0.
// - Assert rst with the FIFO full and 1 in flight ->
//   inst_valid=0 immediately; after release, the first request address is RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: owns the fetch PC, issues word reads to instruction memory,
// buffers in-order responses with their PCs and hands them to decode; redirects squash stale words.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   kill_cnt_q, kill_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] mem_pc_q   [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];

    logic            issue, push, pop;
    logic [CW:0]     in_use;
    logic [XLEN-1:0] redirect_base;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request slots are reserved at issue, so a returning word always has FIFO space.
    always_comb begin
        in_use         = {1'b0, outstanding_q} + {1'b0, count_q};
        imem_req_valid = !rst && !halt && !redirect_valid && (in_use < (CW+1)'(DEPTH));
        issue          = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && (kill_cnt_q == '0) && !redirect_valid;
        pop            = (count_q != '0) && inst_ready && !redirect_valid;
        redirect_base  = redirect_pc & ~XLEN'(3);
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        kill_cnt_d    = kill_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rsp_valid);
        count_d       = count_q + CW'(push) - CW'(pop);

        if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (push) begin
            rsp_pc_d = rsp_pc_q + XLEN'(4);
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (imem_rsp_valid && (kill_cnt_q != '0)) kill_cnt_d = kill_cnt_q - CW'(1);

        // Everything still in flight after this cycle's response belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            kill_cnt_d = outstanding_q - CW'(imem_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
            mem_data_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? mem_data_q[rd_ptr_q] : NOP;
    assign inst_pc    = inst_valid ? mem_pc_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: queue-based reference model, in-order memory model,
// directed scenarios with literal expectations, then a randomized run with a mid-run reset.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] addr; bit live; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    mreq_t       mem_q [$];
    fl_t         m_fl [$];
    ent_t        m_fifo [$];
    logic [31:0] m_pc;
    logic [31:0] issue_log [$];
    logic [31:0] pc_log [$];
    logic [31:0] data_log [$];

    int n_vec = 0, n_miss = 0, cyc = 0;
    int lat_min = 1, lat_max = 1;
    logic        s_ready, s_iready, s_halt, s_redirect;
    logic [31:0] s_rpc;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        issue_log.delete();
        pc_log.delete();
        data_log.delete();
    endtask

    // One clock cycle: apply inputs, compare against the model, then advance the model.
    task automatic cycle();
        logic        exp_rv, rsp;
        logic [31:0] rdata;
        fl_t         f;
        @(posedge clk);
        #1;
        cyc++;
        rsp   = 1'b0;
        rdata = '0;
        f     = '{32'h0, 1'b0};
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rsp   = 1'b1;
            rdata = img(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? rdata : $urandom;
        imem_req_ready = s_ready;
        inst_ready     = s_iready;
        halt           = s_halt;
        redirect_valid = s_redirect;
        redirect_pc    = s_rpc;
        @(negedge clk);
        exp_rv = !s_halt && !s_redirect && (m_fl.size() + m_fifo.size() < 2);
        check("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("imem_addr", imem_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(m_fifo.size() > 0));
        check("inst", inst, (m_fifo.size() > 0) ? m_fifo[0].data : NOP);
        check("inst_pc", inst_pc, (m_fifo.size() > 0) ? m_fifo[0].pc : 32'h0);

        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            issue_log.push_back(imem_addr);
        end
        if (inst_valid && inst_ready) begin
            pc_log.push_back(inst_pc);
            data_log.push_back(inst);
        end

        if (rsp && m_fl.size() > 0) f = m_fl.pop_front();
        if (s_redirect) begin
            m_fifo.delete();
            foreach (m_fl[i]) m_fl[i].live = 1'b0;
            m_pc = s_rpc & ~32'h3;
        end else begin
            if (m_fifo.size() > 0 && s_iready) void'(m_fifo.pop_front());
            if (rsp && f.live) m_fifo.push_back('{f.addr, rdata});
            if (exp_rv && s_ready) begin
                m_fl.push_back('{m_pc, 1'b1});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Asserts reset mid-cycle, checks the outputs immediately, and releases with idle inputs.
    task automatic do_reset();
        @(posedge clk);
        #2;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        rst            = 1'b1;
        #1;
        mem_q.delete();
        m_fl.delete();
        m_fifo.delete();
        m_pc = 32'h0;
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", inst_pc, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        halt           = 1'b1;
        rst            = 1'b0;
        s_ready = 1'b1; s_iready = 1'b1; s_halt = 1'b0; s_redirect = 1'b0; s_rpc = 32'h0;
    endtask

    initial begin
        int n_hi;
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b1; inst_ready = 1'b0;
        s_ready = 1'b1; s_iready = 1'b1; s_halt = 1'b0; s_redirect = 1'b0; s_rpc = 32'h0;
        m_pc = 32'h0;

        // Streaming with a 1-cycle memory.
        do_reset();
        lat_min = 1; lat_max = 1;
        clear_logs();
        repeat (10) cycle();
        check("s1_issue_cnt", 32'(issue_log.size() >= 3), 32'h1);
        check("s1_deliver_cnt", 32'(pc_log.size() >= 3), 32'h1);
        if (issue_log.size() >= 3 && pc_log.size() >= 3) begin
            check("s1_addr0", issue_log[0], 32'h0);
            check("s1_addr1", issue_log[1], 32'h4);
            check("s1_addr2", issue_log[2], 32'h8);
            check("s1_pc0", pc_log[0], 32'h0);
            check("s1_pc1", pc_log[1], 32'h4);
            check("s1_pc2", pc_log[2], 32'h8);
            check("s1_data0", data_log[0], 32'h0000_0013);
            check("s1_data1", data_log[1], 32'h9E37_79B1 * 32'd4 ^ 32'h13);
        end

        // Decode backpressure caps the number of issues at DEPTH.
        do_reset();
        s_iready = 1'b0;
        clear_logs();
        repeat (6) cycle();
        check("s2_issue_cnt", 32'(issue_log.size()), 32'd2);
        s_iready = 1'b1;
        repeat (6) cycle();
        check("s2_deliver_cnt", 32'(pc_log.size() >= 2), 32'h1);
        foreach (pc_log[i]) check("s2_order", pc_log[i], 32'(4 * i));

        // Memory ready toggling 1,0,0,1.
        do_reset();
        clear_logs();
        cycle();
        s_ready = 1'b0;
        cycle();
        check("s3_addr_hold_a", imem_addr, 32'h4);
        cycle();
        check("s3_addr_hold_b", imem_addr, 32'h4);
        s_ready = 1'b1;
        repeat (10) cycle();
        check("s3_deliver_cnt", 32'(pc_log.size() >= 3), 32'h1);
        foreach (pc_log[i]) check("s3_order", pc_log[i], 32'(4 * i));

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        cycle();
        cycle();
        s_redirect = 1'b1; s_rpc = 32'h102;
        cycle();
        s_redirect = 1'b0;
        clear_logs();
        repeat (12) cycle();
        check("s4_issue_cnt", 32'(issue_log.size() >= 1), 32'h1);
        check("s4_deliver_cnt", 32'(pc_log.size() >= 1), 32'h1);
        if (issue_log.size() >= 1) check("s4_first_addr", issue_log[0], 32'h100);
        foreach (pc_log[i]) check("s4_order", pc_log[i], 32'h100 + 32'(4 * i));

        // halt after three issues.
        do_reset();
        lat_min = 1; lat_max = 1;
        clear_logs();
        for (int i = 0; i < 20 && issue_log.size() < 3; i++) cycle();
        s_halt = 1'b1;
        n_hi = 0;
        repeat (10) begin
            cycle();
            if (imem_req_valid) n_hi++;
        end
        check("s5_req_valid_cnt", 32'(n_hi), 32'h0);
        check("s5_issue_cnt", 32'(issue_log.size()), 32'd3);
        check("s5_deliver_cnt", 32'(pc_log.size()), 32'd3);
        foreach (pc_log[i]) check("s5_order", pc_log[i], 32'(4 * i));

        // Reset with a full FIFO.
        do_reset();
        s_iready = 1'b0;
        repeat (5) cycle();
        check("s6_full_valid", 32'(inst_valid), 32'h1);
        check("s6_full_head", inst_pc, 32'h0);
        do_reset();
        clear_logs();
        repeat (4) cycle();
        check("s6_first_addr", (issue_log.size() > 0) ? issue_log[0] : 32'hFFFF_FFFF, 32'h0);

        // Randomized traffic.
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                lat_min = 1; lat_max = 4;
            end
            s_ready    = ($urandom_range(3) != 0);
            s_iready   = ($urandom_range(2) != 0);
            s_redirect = ($urandom_range(15) == 0);
            s_rpc      = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                  : ($urandom & 32'h0000_0FFF);
            if ($urandom_range(39) == 0) s_halt = ~s_halt;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
